// File: rtl/ser8_tx.sv
// Parallel-to-serial transmitter: frames an 8-bit word as start bit, 8 data
// bits LSB first and a stop bit, each held for BIT_CYCLES clocks.
`timescale 1ns/1ps

module ser8_tx #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Res,
  input  logic       load,
  input  logic [7:0] tx_data,
  output logic       ser_out,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] BCNT_LAST = 8'(BIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] bcnt, bcnt_nxt;
  logic [2:0] bidx, bidx_nxt;
  logic       done_nxt;
  logic       bit_end;

  // With BIT_CYCLES=1 the last count is 0, so every edge ends a bit time.
  assign bit_end = (bcnt == BCNT_LAST);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    bidx_nxt  = bidx;
    done_nxt  = 1'b0;
    ready     = 1'b0;
    busy      = 1'b1;
    ser_out   = 1'b1;

    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (load) begin
          shreg_nxt = tx_data;
          bcnt_nxt  = '0;
          state_nxt = START;
        end
      end

      START: begin
        ser_out = 1'b0;
        if (bit_end) begin
          bcnt_nxt  = '0;
          bidx_nxt  = '0;
          state_nxt = DATA;
        end else begin
          bcnt_nxt = bcnt + 8'd1;
        end
      end

      DATA: begin
        ser_out = shreg[0];
        if (bit_end) begin
          bcnt_nxt  = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bidx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bidx_nxt = bidx + 3'd1;
          end
        end else begin
          bcnt_nxt = bcnt + 8'd1;
        end
      end

      STOP: begin
        ser_out = 1'b1;
        if (bit_end) begin
          bcnt_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          bcnt_nxt = bcnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Res) begin
    if (Res) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      bidx  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      bcnt  <= bcnt_nxt;
      bidx  <= bidx_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ser8_tx.sv
// Directed bench for ser8_tx: three instances (BIT_CYCLES 1, 4, 2) driven from
// a vector table plus hand-written reset, back-to-back and ignore sequences.
`timescale 1ns/1ps

module tb_ser8_tx;

  logic       Clk = 1'b0;
  logic [2:0] res;
  logic [2:0] load;
  logic [7:0] data [3];
  logic [2:0] ser, rdy, bsy, dn;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 Clk = ~Clk;

  ser8_tx #(.BIT_CYCLES(1)) u_b1 (
    .Clk(Clk), .Res(res[0]), .load(load[0]), .tx_data(data[0]),
    .ser_out(ser[0]), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0])
  );

  ser8_tx #(.BIT_CYCLES(4)) u_b4 (
    .Clk(Clk), .Res(res[1]), .load(load[1]), .tx_data(data[1]),
    .ser_out(ser[1]), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1])
  );

  ser8_tx #(.BIT_CYCLES(2)) u_b2 (
    .Clk(Clk), .Res(res[2]), .load(load[2]), .tx_data(data[2]),
    .ser_out(ser[2]), .ready(rdy[2]), .busy(bsy[2]), .done(dn[2])
  );

  typedef struct {
    int unsigned inst;
    logic [7:0]  word;
    logic [0:9]  exp;    // line level per symbol, start bit first
    bit          noise;  // toggle tx_data and pulse load mid-frame
  } vec_t;

  vec_t vecs [5];

  function automatic int unsigned bcyc(input int unsigned idx);
    case (idx)
      0:       return 1;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle(input int unsigned idx, input string tag);
    chk($sformatf("%s ser[%0d]", tag, idx), ser[idx], 1'b1);
    chk($sformatf("%s ready[%0d]", tag, idx), rdy[idx], 1'b1);
    chk($sformatf("%s busy[%0d]", tag, idx), bsy[idx], 1'b0);
    chk($sformatf("%s done[%0d]", tag, idx), dn[idx], 1'b0);
  endtask

  task automatic start_frame(input int unsigned idx, input logic [7:0] word, input bit hold);
    data[idx] = word;
    load[idx] = 1'b1;
    step();
    if (!hold) load[idx] = 1'b0;
  endtask

  // Entered in the cycle right after the accepting edge; returns in the done cycle.
  task automatic check_frame(input int unsigned idx, input logic [0:9] exp, input bit noise);
    int unsigned b;
    b = bcyc(idx);
    for (int unsigned s = 0; s < 10; s++) begin
      for (int unsigned c = 0; c < b; c++) begin
        chk($sformatf("ser[%0d] sym %0d", idx, s), ser[idx], exp[s]);
        chk($sformatf("busy[%0d] sym %0d", idx, s), bsy[idx], 1'b1);
        chk($sformatf("ready[%0d] sym %0d", idx, s), rdy[idx], 1'b0);
        chk($sformatf("done[%0d] sym %0d", idx, s), dn[idx], 1'b0);
        if (noise) begin
          data[idx] = 8'($urandom);
          load[idx] = (s == 4 && c == 0);
        end
        step();
      end
    end
    if (noise) load[idx] = 1'b0;
    chk($sformatf("done pulse[%0d]", idx), dn[idx], 1'b1);
    chk($sformatf("done ready[%0d]", idx), rdy[idx], 1'b1);
    chk($sformatf("done busy[%0d]", idx), bsy[idx], 1'b0);
    chk($sformatf("done ser[%0d]", idx), ser[idx], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;

    vecs[0] = '{inst: 0, word: 8'hA5, exp: 10'b0101001011, noise: 1'b0};
    vecs[1] = '{inst: 1, word: 8'h3C, exp: 10'b0001111001, noise: 1'b0};
    vecs[2] = '{inst: 0, word: 8'h0F, exp: 10'b0111100001, noise: 1'b1};
    vecs[3] = '{inst: 0, word: 8'h00, exp: 10'b0000000001, noise: 1'b0};
    vecs[4] = '{inst: 2, word: 8'hFF, exp: 10'b0111111111, noise: 1'b0};

    res  = '1;
    load = '0;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    step();
    step();
    for (int unsigned i = 0; i < 3; i++) chk_idle(i, "reset");
    res = '0;
    step();
    for (int unsigned i = 0; i < 3; i++) chk_idle(i, "post-reset");

    for (int unsigned v = 0; v < 5; v++) begin
      start_frame(vecs[v].inst, vecs[v].word, 1'b0);
      check_frame(vecs[v].inst, vecs[v].exp, vecs[v].noise);
      step();
      chk_idle(vecs[v].inst, $sformatf("after vec %0d", v));
      step();
      chk_idle(vecs[v].inst, $sformatf("settle vec %0d", v));
    end

    // Back-to-back with load held: second frame starts 10B+1 = 21 cycles later.
    start_frame(2, 8'h01, 1'b1);
    a1 = cyc;
    data[2] = 8'h80;
    check_frame(2, 10'b0100000001, 1'b0);
    step();
    a2 = cyc;
    load[2] = 1'b0;
    chk_int("b2b accept gap", a2 - a1, 21);
    check_frame(2, 10'b0000000011, 1'b0);
    step();
    chk_idle(2, "after b2b");

    // Reset in data bit 5 of 0xC3 at a random clock phase.
    start_frame(1, 8'hC3, 1'b0);
    for (int i = 0; i < 25; i++) step();
    chk("pre-reset bit5 ser", ser[1], 1'b0);
    chk("pre-reset busy", bsy[1], 1'b1);
    #($urandom_range(1, 6));
    res[1] = 1'b1;
    #1;
    chk_idle(1, "async reset");
    step();
    chk_idle(1, "reset hold 1");
    step();
    chk_idle(1, "reset hold 2");
    res[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle(1, "post-abort");
    end
    start_frame(1, 8'h55, 1'b0);
    check_frame(1, 10'b0101010101, 1'b0);
    step();
    chk_idle(1, "after 0x55");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
